// File: rtl/gpu_pkg.sv
// gpu_pkg: shared screen geometry, pixel type and line-buffer state encoding
package gpu_pkg;
   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int PIX_W = 24;
   typedef logic [PIX_W-1:0] rgb24_t;
   typedef enum logic [1:0] {LB_IDLE, LB_REQ, LB_FILL} lb_state_t;
   // Row to prefetch during the blank of row y; the last row wraps to the top
   function automatic logic [8:0] next_row(input logic [8:0] y);
      return (y == 9'(SCREEN_H - 1)) ? 9'd0 : y + 9'd1;
   endfunction
endpackage

// File: rtl/vga_line_buffer_if.sv
// vga_line_buffer_if: row-fetch request and pixel write bus between VRAM arbiter and line buffer
interface vga_line_buffer_if;
   import gpu_pkg::*;
   logic vram_re;
   logic [8:0] vram_y;
   logic wr_en;
   logic [9:0] wr_x;
   rgb24_t wr_data;
   modport master(input vram_re, vram_y, output wr_en, wr_x, wr_data);
   modport slave(output vram_re, vram_y, input wr_en, wr_x, wr_data);
endinterface

// File: rtl/line_bank.sv
// line_bank: one scan-line bank, simple dual-port RAM with synchronous write and registered read
module line_bank
   import gpu_pkg::*;
#(
   parameter int DEPTH = SCREEN_W,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  rgb24_t        wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output rgb24_t        rdata
);
   rgb24_t mem [DEPTH];
   rgb24_t rdata_q;
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end
   assign rdata = rdata_q;
endmodule

// File: rtl/vga_line_buffer.sv
// vga_line_buffer: ping-pong scan-line buffer; fills the back bank from VRAM while the
// front bank feeds the VGA pixel pipeline
module vga_line_buffer
   import gpu_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                line_start,
   input  logic [8:0]          disp_y,
   input  logic [9:0]          disp_x,
   input  logic                disp_active,
   output rgb24_t              pixel_out,
   vga_line_buffer_if.slave    vram,
   output logic                fill_busy,
   output logic                underrun,
   input  logic                clr_underrun
);
   lb_state_t state_q, state_d;
   logic bank_q, bank_d;
   logic [8:0] target_q, target_d;
   logic [9:0] cnt_q, cnt_d;
   logic underrun_q, underrun_d;
   logic rd_v_q, rd_v_d;
   logic sel_q, sel_d;
   logic go, accept, rd_en;
   rgb24_t rd0, rd1;
   always_comb begin
      go = line_start && state_q == LB_IDLE;
      accept = state_q == LB_FILL && vram.wr_en && vram.wr_x < 10'(SCREEN_W);
      rd_en = disp_active && disp_x < 10'(SCREEN_W);
      bank_d = bank_q ^ go;
      target_d = go ? next_row(disp_y) : target_q;
      cnt_d = (state_q == LB_REQ) ? 10'd0 : cnt_q + 10'(accept);
      state_d = go ? LB_REQ :
                (state_q == LB_REQ) ? LB_FILL :
                (state_q == LB_FILL && cnt_d == 10'(SCREEN_W)) ? LB_IDLE : state_q;
      underrun_d = (line_start && state_q != LB_IDLE) || (underrun_q && !clr_underrun);
      rd_v_d = rd_en;
      sel_d = bank_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LB_IDLE;
         bank_q <= 1'b0;
         target_q <= '0;
         cnt_q <= '0;
         underrun_q <= 1'b0;
         rd_v_q <= 1'b0;
         sel_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bank_q <= bank_d;
         target_q <= target_d;
         cnt_q <= cnt_d;
         underrun_q <= underrun_d;
         rd_v_q <= rd_v_d;
         sel_q <= sel_d;
      end
   end
   // bank_q names the front bank; writes go to the other one
   line_bank u_bank0 (
      .clk(clk), .we(accept && bank_q), .waddr(vram.wr_x[8:0]), .wdata(vram.wr_data),
      .re(rd_en), .raddr(disp_x[8:0]), .rdata(rd0)
   );
   line_bank u_bank1 (
      .clk(clk), .we(accept && !bank_q), .waddr(vram.wr_x[8:0]), .wdata(vram.wr_data),
      .re(rd_en), .raddr(disp_x[8:0]), .rdata(rd1)
   );
   assign pixel_out = rd_v_q ? (sel_q ? rd1 : rd0) : '0;
   assign fill_busy = state_q != LB_IDLE;
   assign underrun = underrun_q;
   assign vram.vram_re = state_q == LB_REQ;
   assign vram.vram_y = target_q;
endmodule

// File: tb/tb_vga_line_buffer.sv
// tb_vga_line_buffer: directed stimulus with a row-image model checked every cycle
module tb_vga_line_buffer;
   import gpu_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic line_start = 1'b0;
   logic [8:0] disp_y = '0;
   logic [9:0] disp_x = '0;
   logic disp_active = 1'b0;
   logic clr_underrun = 1'b0;
   rgb24_t pixel_out;
   logic fill_busy, underrun;
   int checks = 0;
   int errors = 0;
   vga_line_buffer_if vif();
   vga_line_buffer dut (
      .clk(clk), .rst(rst), .line_start(line_start), .disp_y(disp_y), .disp_x(disp_x),
      .disp_active(disp_active), .pixel_out(pixel_out), .vram(vif.slave),
      .fill_busy(fill_busy), .underrun(underrun), .clr_underrun(clr_underrun)
   );
   always #5 clk = ~clk;

   rgb24_t mf [SCREEN_W];
   rgb24_t mb [SCREEN_W];
   bit fk [SCREEN_W];
   bit bk [SCREEN_W];
   bit m_busy, m_req, m_und, m_pchk;
   int m_cnt;
   logic [8:0] m_tgt;
   rgb24_t m_pix;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s act=%h exp=%h at %0t", n, a, e, $time);
      end
   endtask

   // Model: front/back row images swap on an accepted line_start
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_busy = 0; m_req = 0; m_und = 0; m_cnt = 0; m_tgt = 0; m_pix = 0; m_pchk = 1;
         for (int i = 0; i < SCREEN_W; i++) begin fk[i] = 0; bk[i] = 0; end
      end else begin
         bit busy0;
         busy0 = m_busy;
         m_pix = 0; m_pchk = 1;
         if (disp_active && disp_x < 10'(SCREEN_W)) begin
            m_pix = mf[disp_x];
            m_pchk = fk[disp_x];
         end
         if (m_req) begin
            m_req = 0; m_cnt = 0;
         end else if (busy0 && vif.wr_en && vif.wr_x < 10'(SCREEN_W)) begin
            mb[vif.wr_x] = vif.wr_data; bk[vif.wr_x] = 1; m_cnt++;
            if (m_cnt == SCREEN_W) m_busy = 0;
         end
         if (line_start && !busy0) begin
            for (int i = 0; i < SCREEN_W; i++) begin
               rgb24_t t; bit tk;
               t = mf[i]; mf[i] = mb[i]; mb[i] = t;
               tk = fk[i]; fk[i] = bk[i]; bk[i] = tk;
            end
            m_tgt = (disp_y == 9'(SCREEN_H - 1)) ? 9'd0 : disp_y + 9'd1;
            m_req = 1; m_busy = 1;
         end
         m_und = (line_start && busy0) || (m_und && !clr_underrun);
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (m_pchk) chk("pixel_out", 32'(pixel_out), 32'(m_pix));
         chk("fill_busy", 32'(fill_busy), 32'(m_busy));
         chk("vram_re", 32'(vif.vram_re), 32'(m_req));
         chk("vram_y", 32'(vif.vram_y), 32'(m_tgt));
         chk("underrun", 32'(underrun), 32'(m_und));
      end
   end

   task automatic step(); @(negedge clk); endtask
   task automatic pulse_ls(input logic [8:0] y, input logic clr);
      line_start = 1; disp_y = y; clr_underrun = clr;
      step();
      line_start = 0; clr_underrun = 0;
   endtask
   task automatic fill(input int x0, input int n, input logic [13:0] tag);
      for (int i = 0; i < n; i++) begin
         vif.wr_en = 1; vif.wr_x = 10'(x0 + i); vif.wr_data = {10'(x0 + i), tag};
         step();
      end
      vif.wr_en = 0;
   endtask
   task automatic wr_bad(input logic [9:0] x);
      vif.wr_en = 1; vif.wr_x = x; vif.wr_data = 24'hBADBAD;
      step();
      vif.wr_en = 0;
   endtask
   task automatic sweep(input int n);
      for (int x = 0; x < n; x++) begin disp_active = 1; disp_x = 10'(x); step(); end
      disp_active = 0;
   endtask

   initial begin
      vif.wr_en = 0; vif.wr_x = '0; vif.wr_data = '0;
      step(); step();
      rst = 0;
      step();
      chk("rst_pixel", 32'(pixel_out), 0);
      chk("rst_vram_re", 32'(vif.vram_re), 0);
      chk("rst_vram_y", 32'(vif.vram_y), 0);
      chk("rst_busy", 32'(fill_busy), 0);
      chk("rst_underrun", 32'(underrun), 0);
      // Row 5 blank fetches row 6
      pulse_ls(9'd5, 0);
      chk("t1_vram_re", 32'(vif.vram_re), 1);
      chk("t1_vram_y", 32'(vif.vram_y), 6);
      step();
      chk("t1_re_once", 32'(vif.vram_re), 0);
      chk("t1_busy", 32'(fill_busy), 1);
      fill(0, SCREEN_W - 1, 14'h0);
      chk("t1_busy_319", 32'(fill_busy), 1);
      fill(SCREEN_W - 1, 1, 14'h0);
      step();
      chk("t1_busy_done", 32'(fill_busy), 0);
      pulse_ls(9'd6, 0);
      disp_active = 1; disp_x = 10'd17;
      step();
      chk("t1_pixel17", 32'(pixel_out), 32'({10'd17, 14'h0}));
      disp_active = 0;
      step();
      fill(0, SCREEN_W, 14'h0007);
      sweep(SCREEN_W);
      // Out-of-range and inactive reads
      disp_active = 1; disp_x = 10'd320;
      step();
      chk("t5_x320", 32'(pixel_out), 0);
      disp_active = 0; disp_x = 10'd5;
      step();
      chk("t5_inactive", 32'(pixel_out), 0);
      // Last row wraps to row 0
      pulse_ls(9'd239, 0);
      chk("t2_vram_re", 32'(vif.vram_re), 1);
      chk("t2_vram_y", 32'(vif.vram_y), 0);
      step();
      sweep(40);
      // Early line_start: underrun, no new request, fill completes
      fill(0, 100, 14'h00AA);
      pulse_ls(9'd10, 0);
      chk("t3_underrun", 32'(underrun), 1);
      chk("t3_no_re", 32'(vif.vram_re), 0);
      chk("t3_vram_y", 32'(vif.vram_y), 0);
      fill(100, 50, 14'h00AA);
      pulse_ls(9'd11, 1);
      chk("t3_set_wins", 32'(underrun), 1);
      fill(150, SCREEN_W - 150, 14'h00AA);
      step();
      chk("t3_busy_done", 32'(fill_busy), 0);
      sweep(SCREEN_W);
      clr_underrun = 1;
      step();
      clr_underrun = 0;
      chk("t3_cleared", 32'(underrun), 0);
      pulse_ls(9'd20, 0);
      step();
      sweep(SCREEN_W);
      // Invalid columns are ignored
      fill(0, SCREEN_W - 1, 14'h0155);
      wr_bad(10'd320);
      wr_bad(10'd1023);
      chk("t4_still_busy", 32'(fill_busy), 1);
      fill(SCREEN_W - 1, 1, 14'h0155);
      step();
      chk("t4_done", 32'(fill_busy), 0);
      pulse_ls(9'd30, 0);
      step();
      sweep(SCREEN_W);
      // Reset mid-fill
      fill(0, 100, 14'h0222);
      pulse_ls(9'd31, 0);
      fill(100, 50, 14'h0222);
      chk("t6_pre_und", 32'(underrun), 1);
      rst = 1;
      #1;
      chk("t6_pixel", 32'(pixel_out), 0);
      chk("t6_busy", 32'(fill_busy), 0);
      chk("t6_vram_re", 32'(vif.vram_re), 0);
      chk("t6_vram_y", 32'(vif.vram_y), 0);
      chk("t6_underrun", 32'(underrun), 0);
      step(); step();
      rst = 0;
      step();
      pulse_ls(9'd31, 0);
      chk("t6_vram_y2", 32'(vif.vram_y), 32);
      step();
      fill(0, SCREEN_W - 1, 14'h0333);
      chk("t6_fresh_cnt", 32'(fill_busy), 1);
      fill(SCREEN_W - 1, 1, 14'h0333);
      step();
      chk("t6_done", 32'(fill_busy), 0);
      pulse_ls(9'd32, 0);
      step();
      disp_active = 1; disp_x = 10'd300;
      step();
      chk("t6_pixel300", 32'(pixel_out), 32'({10'd300, 14'h0333}));
      disp_active = 0;
      sweep(SCREEN_W);
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
